// File: rtl/btn_move_scheduler.sv
// btn_move_scheduler: turns synchronized button rising edges into queued, locked-out cursor moves on an 8x8 matrix (clk/reset, 4 buttons, move_ready in; move_valid/X, pos_row/pos_col, edge_hit/overflow out)
module btn_move_scheduler #(
  parameter int LOCKOUT_CYC = 4,
  parameter int START_ROW = 7,
  parameter int START_COL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnTop,
  input  logic       btnBottom,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] X,
  output logic [2:0] pos_row,
  output logic [2:0] pos_col,
  output logic       edge_hit,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, PRESENT, LOCKOUT} state_t;
  state_t state_q, state_d;
  logic [3:0] s1_q, s2_q, prev_q, rise, lock_q, lock_d;
  logic [1:0][1:0] fifo_q, fifo_d;
  logic [1:0] cnt_q, cnt_d, x_q, x_d, win;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic hit_q, hit_d, ovf_q, push, pop, drop, accept, widx;
  assign rise = s2_q & ~prev_q;
  assign win = rise[0] ? 2'd0 : rise[1] ? 2'd1 : rise[2] ? 2'd2 : 2'd3;
  assign pop = state_q == IDLE && cnt_q != 2'd0;
  assign push = |rise && (cnt_q != 2'd2 || pop);
  assign drop = |rise && cnt_q == 2'd2 && !pop;
  assign accept = state_q == PRESENT && move_ready;
  assign widx = cnt_q[1] | (cnt_q[0] & ~pop);
  always_comb begin
    fifo_d = fifo_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    if (pop) fifo_d[0] = fifo_q[1];
    if (push) fifo_d[widx] = win;
  end
  always_comb begin
    state_d = state_q;
    lock_d = lock_q;
    x_d = x_q;
    row_d = row_q;
    col_d = col_q;
    hit_d = 1'b0;
    if (pop) begin
      state_d = PRESENT;
      x_d = fifo_q[0];
    end
    if (accept) begin
      state_d = LOCKOUT_CYC == 0 ? IDLE : LOCKOUT;
      lock_d = 4'(LOCKOUT_CYC);
      hit_d = (x_q == 2'd0 && row_q == 3'd0) || (x_q == 2'd1 && row_q == 3'd7) ||
              (x_q == 2'd2 && col_q == 3'd0) || (x_q == 2'd3 && col_q == 3'd7);
      row_d = hit_d ? row_q : x_q == 2'd0 ? row_q - 3'd1 : x_q == 2'd1 ? row_q + 3'd1 : row_q;
      col_d = hit_d ? col_q : x_q == 2'd2 ? col_q - 3'd1 : x_q == 2'd3 ? col_q + 3'd1 : col_q;
    end
    if (state_q == LOCKOUT) begin
      lock_d = lock_q - 4'd1;
      state_d = lock_q <= 4'd1 ? IDLE : LOCKOUT;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
      fifo_q <= '0;
      cnt_q <= '0;
      lock_q <= '0;
      x_q <= '0;
      row_q <= 3'(START_ROW);
      col_q <= 3'(START_COL);
      hit_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q <= {btnRight, btnLeft, btnBottom, btnTop};
      s2_q <= s1_q;
      prev_q <= s2_q;
      fifo_q <= fifo_d;
      cnt_q <= cnt_d;
      lock_q <= lock_d;
      x_q <= x_d;
      row_q <= row_d;
      col_q <= col_d;
      hit_q <= hit_d;
      ovf_q <= drop;
    end
  end
  assign move_valid = state_q == PRESENT;
  assign X = x_q;
  assign pos_row = row_q;
  assign pos_col = col_q;
  assign edge_hit = hit_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_btn_move_scheduler.sv
// tb_btn_move_scheduler: scoreboard bench with directed and random button presses against a queue-based move model
module tb_btn_move_scheduler;
  logic clk = 1'b0, reset = 1'b1;
  logic bt = 1'b0, bb = 1'b0, bl = 1'b0, br = 1'b0, move_ready = 1'b0;
  logic move_valid, edge_hit, overflow;
  logic [1:0] X;
  logic [2:0] pos_row, pos_col;
  int checks = 0, failures = 0;
  int ovf_cnt = 0, ovf_exp = 0, cyc = 0, last_acc = -1;
  int m_row = 7, m_col = 0, m_hit = 0;
  bit pend = 0, rnd = 0, was_valid = 0;
  logic [1:0] prev_x = 2'd0;
  int sb[$];
  int acc_log[$];

  btn_move_scheduler dut (
    .clk(clk), .reset(reset), .btnTop(bt), .btnBottom(bb), .btnLeft(bl), .btnRight(br),
    .move_ready(move_ready), .move_valid(move_valid), .X(X), .pos_row(pos_row),
    .pos_col(pos_col), .edge_hit(edge_hit), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int winner(logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  always @(negedge clk) begin
    int e;
    cyc++;
    if (pend) begin
      chk("pos_row", pos_row, m_row);
      chk("pos_col", pos_col, m_col);
      chk("edge_hit", edge_hit, m_hit);
      pend = 0;
    end else if (edge_hit) chk("spurious_edge_hit", edge_hit, 0);
    if (overflow) ovf_cnt++;
    if (move_valid && was_valid) chk("X_stable", X, prev_x);
    was_valid = move_valid && !move_ready;
    prev_x = X;
    if (reset) begin
      sb.delete();
      m_row = 7;
      m_col = 0;
      last_acc = -1;
      was_valid = 0;
    end else if (move_valid && move_ready) begin
      if (sb.size() == 0) chk("unexpected_move", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("X", X, e);
        m_hit = 0;
        case (e)
          0: if (m_row == 0) m_hit = 1; else m_row--;
          1: if (m_row == 7) m_hit = 1; else m_row++;
          2: if (m_col == 0) m_hit = 1; else m_col--;
          default: if (m_col == 7) m_hit = 1; else m_col++;
        endcase
        pend = 1;
      end
      if (last_acc >= 0) chk("lockout_gap_ok", int'(cyc - last_acc >= 6), 1);
      last_acc = cyc;
      acc_log.push_back(cyc);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd) move_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic press(logic [3:0] m, int hold, bit exp);
    if (exp) sb.push_back(winner(m));
    {br, bl, bb, bt} = m;
    tick(hold);
    {br, bl, bb, bt} = 4'd0;
    tick(3);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || move_valid || pend) && n < 400) begin
      tick(1);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    int n;
    tick(2);
    chk("rst_move_valid", move_valid, 0);
    chk("rst_X", X, 0);
    chk("rst_row", pos_row, 7);
    chk("rst_col", pos_col, 0);
    chk("rst_edge_hit", edge_hit, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    move_ready = 1'b1;
    tick(1);
    sb.push_back(0);
    bt = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("latency_early", move_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_on_time", move_valid, 1);
    tick(1);
    bt = 1'b0;
    drain();
    do_reset();
    press(4'b0100, 2, 1);
    drain();
    press(4'b1001, 2, 1);
    drain();
    tick(3);
    chk("simul_no_overflow", ovf_cnt, ovf_exp);
    do_reset();
    move_ready = 1'b0;
    press(4'b1000, 2, 1);
    press(4'b0010, 2, 1);
    press(4'b0100, 2, 1);
    press(4'b0001, 2, 0);
    ovf_exp++;
    tick(4);
    chk("overflow_count", ovf_cnt, ovf_exp);
    acc_log.delete();
    move_ready = 1'b1;
    drain();
    chk("accept_count", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk("gap1", acc_log[1] - acc_log[0], 6);
      chk("gap2", acc_log[2] - acc_log[1], 6);
    end
    do_reset();
    acc_log.delete();
    press(4'b0010, 20, 1);
    tick(10);
    drain();
    chk("hold_one_move", acc_log.size(), 1);
    do_reset();
    move_ready = 1'b0;
    sb.push_back(3);
    br = 1'b1;
    tick(2);
    br = 1'b0;
    n = 0;
    while (!move_valid && n < 20) begin
      tick(1);
      n++;
    end
    chk("present_before_reset", move_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_move_valid", move_valid, 0);
    chk("abort_row", pos_row, 7);
    chk("abort_col", pos_col, 0);
    bt = 1'b1;
    tick(2);
    reset = 1'b0;
    move_ready = 1'b1;
    sb.push_back(0);
    tick(15);
    bt = 1'b0;
    drain();
    chk("held_across_reset_row", pos_row, 6);
    do_reset();
    rnd = 1;
    for (int i = 0; i < 60; i++) begin
      n = 0;
      while (sb.size() > 1 && n < 100) begin
        tick(1);
        n++;
      end
      press(4'($urandom_range(1, 15)), $urandom_range(1, 4), 1);
      tick($urandom_range(0, 6));
    end
    drain();
    rnd = 0;
    tick(3);
    chk("overflow_total", ovf_cnt, ovf_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
